// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, answers after a fixed
// latency and holds the response until the pipeline takes it.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] txn_count
);

    localparam int unsigned IDXW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] txn_q, txn_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            finish;
    logic            handshake;
    logic            addr_err;
    logic            mem_we;
    logic [IDXW-1:0] idx;

    assign accept    = (state_q == IDLE) && req_valid;
    assign finish    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign handshake = (state_q == RESP) && resp_ready;
    assign idx       = addr_q[IDXW+1:2];
    // Anything above the array's byte span is out of range.
    assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:IDXW+2] != '0);
    assign mem_we    = finish && we_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        txn_d   = txn_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = addr_err;
                    rdata_d = (!we_q && !addr_err) ? mem[idx] : 32'h0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    txn_d   = txn_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            txn_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    // Request fields are pure data; they only matter once state leaves IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign txn_count  = txn_q;

    // handshake is kept as a named term for readability of the RESP exit.
    logic unused_handshake;
    assign unused_handshake = handshake;

endmodule
